// File: rtl/cic_comp_fir_if.sv
// Sample/strobe bundle between the compensation FIR and its neighbours.
//   data_in  : signed input sample, qualified by in_dv
//   in_dv    : one-cycle input strobe
//   data_out : signed filtered sample, held between updates
//   out_dv   : one-cycle pulse, coincident with a data_out update
//   busy     : filter is processing a sample; strobes are dropped while high
//   overrun  : sticky, a strobe arrived while busy
// slave is the filter side, master is the producer/consumer side.
interface cic_comp_fir_if #(
   parameter int dw = 10
);
   logic [dw-1:0] data_in;
   logic          in_dv;
   logic [dw-1:0] data_out;
   logic          out_dv;
   logic          busy;
   logic          overrun;

   modport slave (
      input  data_in,
      input  in_dv,
      output data_out,
      output out_dv,
      output busy,
      output overrun
   );

   modport master (
      output data_in,
      output in_dv,
      input  data_out,
      input  out_dv,
      input  busy,
      input  overrun
   );
endinterface

// File: rtl/cic_comp_fir.sv
// Serial-MAC compensation FIR ahead of the CIC interpolator. Each accepted strobe
// shifts the delay line, then one tap per cycle is accumulated, and the scaled,
// saturated result is emitted with a one-cycle out_dv.
//   clk     : system clock
//   reset_n : synchronous active-low reset
//   bus     : cic_comp_fir_if.slave (data_in/in_dv in, data_out/out_dv/busy/overrun out)
module cic_comp_fir #(
   parameter int                  dw    = 10,
   parameter int                  cw    = 10,
   parameter int                  ntaps = 5,
   // tap 0 in the LSBs, applied to the newest sample
   parameter logic [ntaps*cw-1:0] coefs = {-10'sd32, 10'sd64, 10'sd448, 10'sd64, -10'sd32},
   parameter int                  shift = 9
) (
   input logic           clk,
   input logic           reset_n,
   cic_comp_fir_if.slave bus
);
   localparam int pw = dw + cw;
   localparam int aw = pw + $clog2(ntaps);
   localparam int kw = $clog2(ntaps);

   typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

   state_e                 state_q, state_d;
   logic signed [dw-1:0]   x_q [ntaps];
   logic signed [dw-1:0]   x_d [ntaps];
   logic signed [aw-1:0]   acc_q, acc_d;
   logic        [kw-1:0]   k_q, k_d;
   logic        [dw-1:0]   data_out_q, data_out_d;
   logic                   out_dv_q, out_dv_d;
   logic                   busy_q, busy_d;
   logic                   overrun_q, overrun_d;

   logic signed [cw-1:0]   coef_k;
   logic signed [dw-1:0]   x_k;
   logic signed [pw-1:0]   prod;
   logic signed [aw-1:0]   prod_ext;
   logic signed [aw-1:0]   shifted;
   logic        [dw-1:0]   sat_val;

   assign coef_k   = signed'(coefs[k_q*cw +: cw]);
   assign x_k      = x_q[k_q];
   assign prod     = x_k * coef_k;
   assign prod_ext = aw'(prod);
   assign shifted  = acc_q >>> shift;

   // Clamp when the bits above the output sign bit are not a pure sign extension.
   always_comb begin
      sat_val = shifted[dw-1:0];
      if (shifted[aw-1:dw-1] != {(aw-dw+1){shifted[aw-1]}}) begin
         sat_val = shifted[aw-1] ? {1'b1, {(dw-1){1'b0}}} : {1'b0, {(dw-1){1'b1}}};
      end
   end

   always_comb begin
      state_d    = state_q;
      x_d        = x_q;
      acc_d      = acc_q;
      k_d        = k_q;
      data_out_d = data_out_q;
      out_dv_d   = 1'b0;
      busy_d     = busy_q;
      overrun_d  = overrun_q;

      unique case (state_q)
         StIdle: begin
            if (bus.in_dv) begin
               x_d[0] = signed'(bus.data_in);
               for (int i = 1; i < ntaps; i++) begin
                  x_d[i] = x_q[i-1];
               end
               acc_d   = '0;
               k_d     = '0;
               busy_d  = 1'b1;
               state_d = StMac;
            end
         end
         StMac: begin
            acc_d = acc_q + prod_ext;
            k_d   = k_q + kw'(1);
            if (k_q == kw'(ntaps - 1)) begin
               state_d = StOut;
            end
         end
         StOut: begin
            data_out_d = sat_val;
            out_dv_d   = 1'b1;
            busy_d     = 1'b0;
            state_d    = StIdle;
         end
         default: state_d = StIdle;
      endcase

      // Strobes during processing are dropped; only the sticky flag records them.
      if (bus.in_dv && busy_q) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         for (int i = 0; i < ntaps; i++) begin
            x_q[i] <= '0;
         end
         acc_q      <= '0;
         k_q        <= '0;
         data_out_q <= '0;
         out_dv_q   <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         x_q        <= x_d;
         acc_q      <= acc_d;
         k_q        <= k_d;
         data_out_q <= data_out_d;
         out_dv_q   <= out_dv_d;
         busy_q     <= busy_d;
         overrun_q  <= overrun_d;
      end
   end

   assign bus.data_out = data_out_q;
   assign bus.out_dv   = out_dv_q;
   assign bus.busy     = busy_q;
   assign bus.overrun  = overrun_q;
endmodule

// File: tb/tb_cic_comp_fir.sv
// Self-checking bench for cic_comp_fir: a reference model computes each accepted
// sample's expected output and output edge; a monitor pops and compares on out_dv.
module tb_cic_comp_fir;
   localparam int dw    = 10;
   localparam int ntaps = 5;
   localparam int shift = 9;
   localparam int coef_tab [ntaps] = '{-32, 64, 448, 64, -32};

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   cic_comp_fir_if #(.dw(dw)) bus ();

   cic_comp_fir dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int data;
      int edge_no;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   errors   = 0;
   int   edge_cnt = 0;
   int   hist [ntaps];
   int   last_acc = -100;
   int   ovr_exp  = 0;

   always @(posedge clk) edge_cnt++;

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d (edge %0d)", tag, got, exp, edge_cnt);
      end
   endtask

   // Monitor: every out_dv must match the next queued expectation, value and edge.
   exp_t mon_x;
   always @(negedge clk) begin
      if (reset_n && bus.out_dv) begin
         if (sb.size() == 0) begin
            check_eq("spurious_out_dv", 1, 0);
         end else begin
            mon_x = sb.pop_front();
            check_eq("data_out", int'($signed(bus.data_out)), mon_x.data);
            check_eq("out_edge", edge_cnt, mon_x.edge_no);
         end
      end
   end

   task automatic model_clear();
      for (int i = 0; i < ntaps; i++) hist[i] = 0;
      sb.delete();
      last_acc = -100;
      ovr_exp  = 0;
   endtask

   // Drive one strobe, sampled at the next rising edge; returns 1ns after it.
   task automatic send(input int v);
      int   e;
      int   acc;
      int   r;
      exp_t x;
      bus.data_in = v[dw-1:0];
      bus.in_dv   = 1'b1;
      e = edge_cnt + 1;
      if (e - last_acc >= ntaps + 2) begin
         for (int i = ntaps - 1; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = v;
         acc = 0;
         for (int i = 0; i < ntaps; i++) acc += hist[i] * coef_tab[i];
         r = acc >>> shift;
         if (r > 511) r = 511;
         if (r < -512) r = -512;
         x.data    = r;
         x.edge_no = e + ntaps + 1;
         sb.push_back(x);
         last_acc = e;
      end else begin
         ovr_exp = 1;
      end
      @(posedge clk);
      #1;
      bus.in_dv   = 1'b0;
      bus.data_in = '0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_reset();
      reset_n = 1'b0;
      idle(1);
      model_clear();
      reset_n = 1'b1;
   endtask

   initial begin
      bus.in_dv   = 1'b0;
      bus.data_in = '0;
      model_clear();
      idle(3);

      // Reset state
      @(negedge clk);
      check_eq("rst_data_out", int'($signed(bus.data_out)), 0);
      check_eq("rst_out_dv", int'(bus.out_dv), 0);
      check_eq("rst_busy", int'(bus.busy), 0);
      check_eq("rst_overrun", int'(bus.overrun), 0);
      idle(1);
      reset_n = 1'b1;
      idle(2);

      // Impulse response
      send(511);
      idle(7);
      repeat (5) begin
         send(0);
         idle(7);
      end
      check_eq("impulse_tail", int'($signed(bus.data_out)), 0);

      // DC gain, positive then negative, at minimum spacing
      repeat (6) begin
         send(100);
         idle(6);
      end
      idle(1);
      check_eq("dc_pos", int'($signed(bus.data_out)), 100);
      repeat (6) begin
         send(-100);
         idle(6);
      end
      idle(1);
      check_eq("dc_neg", int'($signed(bus.data_out)), -100);

      // Saturation, both rails
      send(-512); idle(6);
      send(511);  idle(6);
      send(511);  idle(6);
      send(511);  idle(6);
      send(-512); idle(7);
      check_eq("sat_hi", int'($signed(bus.data_out)), 511);
      send(511);  idle(6);
      send(-512); idle(6);
      send(-512); idle(6);
      send(-512); idle(6);
      send(511);  idle(7);
      check_eq("sat_lo", int'($signed(bus.data_out)), -512);

      // Latency and busy window, then a back-to-back strobe at spacing 7
      send(50);
      for (int i = 0; i <= ntaps + 1; i++) begin
         @(negedge clk);
         check_eq($sformatf("busy_%0d", i), int'(bus.busy), (i <= ntaps) ? 1 : 0);
         check_eq($sformatf("out_dv_%0d", i), int'(bus.out_dv), (i == ntaps + 1) ? 1 : 0);
      end
      send(60);
      @(negedge clk);
      check_eq("spacing_busy", int'(bus.busy), 1);
      check_eq("spacing_no_ovr", int'(bus.overrun), 0);
      idle(8);

      // Overrun: second strobe three edges after the first is dropped
      send(200);
      idle(2);
      send(300);
      @(negedge clk);
      check_eq("ovr_set", int'(bus.overrun), ovr_exp);
      idle(10);
      send(0);
      idle(8);
      check_eq("ovr_sticky", int'(bus.overrun), 1);
      pulse_reset();
      @(negedge clk);
      check_eq("ovr_cleared", int'(bus.overrun), 0);
      idle(2);

      // Reset mid-MAC: no output, delay line cleared
      send(300);
      idle(1);
      pulse_reset();
      @(negedge clk);
      check_eq("rst_mid_busy", int'(bus.busy), 0);
      idle(10);
      send(511);
      idle(7);
      check_eq("post_rst_impulse", int'($signed(bus.data_out)), -32);

      // Drain, bounded
      for (int i = 0; i < 20 && sb.size() != 0; i++) idle(1);
      check_eq("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
